// File: rtl/common_pkg.sv
// Shared types and constants for the pipeline.
//   control_t  : decoded control word travelling alongside each instruction
//   MEM_*      : mem_funct3 access-size/extension codes
//   access_aligned() : true when an access of the given code may start at
//                      the given byte offset within a word
package common_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic [4:0] rd;
  } control_t;

  // Unknown size codes report as unaligned, so a bad funct3 on a memory
  // instruction is squashed the same way as a misaligned address.
  function automatic logic access_aligned(input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (funct3)
      MEM_B, MEM_BU: ok = 1'b1;
      MEM_H, MEM_HU: ok = ~offset[0];
      MEM_W:         ok = (offset == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM, 32-bit words with per-byte write enable.
//   clk   : clock
//   en    : access enable; when low neither write nor read register changes
//   we    : byte write enables (bit b writes wdata[8b+7:8b])
//   addr  : word index
//   wdata : write data (already replicated into the right lanes)
//   rdata : registered read data (old contents on a simultaneous write)
// Contents are never reset.
import common_pkg::*;

module data_ram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_array [DEPTH_WORDS];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_array[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata_reg <= mem_array[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: byte/half/word loads and stores on a private RAM,
// registering the result into the MEM/WB boundary (latency 1).
//   clk, rst    : clock, synchronous active-high reset (priority over stall)
//   alu_res     : byte address for memory ops, pass-through value otherwise
//   mem_data    : right-aligned store data
//   control     : decoded control word
//   stall       : freeze the stage (no RAM access, all outputs hold)
//   wb_alu_res  : registered alu_res
//   wb_mem_data : lane-extracted, sign/zero-extended load data (0 otherwise)
//   wb_control  : registered control, reg_write cleared on misaligned access
//   misaligned  : misaligned / bad-size flag for the access now at WB
import common_pkg::*;

module memory_stage #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_data,
  input  control_t    control,
  input  logic        stall,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output control_t    wb_control,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic          mem_op;
  logic          is_misaligned;
  logic          is_store;
  logic          is_load;
  logic [3:0]    byte_en;
  logic [31:0]   store_word;
  logic [3:0]    ram_we;
  logic          ram_en;
  logic [31:0]   ram_rdata;
  control_t      control_next;

  logic [31:0]   wb_alu_res_reg;
  control_t      wb_control_reg;
  logic          misaligned_reg;
  logic          load_valid_reg;
  logic [1:0]    lane_reg;
  logic [2:0]    funct3_reg;

  assign mem_op        = control.mem_read | control.mem_write;
  assign is_misaligned = mem_op & ~access_aligned(control.mem_funct3, alu_res[1:0]);
  // Read+write together is handled as a store, so it never produces load data.
  assign is_store      = control.mem_write & ~is_misaligned;
  assign is_load       = control.mem_read & ~control.mem_write & ~is_misaligned;

  // Store data is replicated into every lane; byte_en picks the live ones.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = mem_data;
    case (control.mem_funct3)
      MEM_B: begin
        byte_en    = 4'b0001 << alu_res[1:0];
        store_word = {4{mem_data[7:0]}};
      end
      MEM_H: begin
        byte_en    = alu_res[1] ? 4'b1100 : 4'b0011;
        store_word = {2{mem_data[15:0]}};
      end
      MEM_W: begin
        byte_en    = 4'b1111;
        store_word = mem_data;
      end
      default: begin
        byte_en    = 4'b0000;
        store_word = mem_data;
      end
    endcase
  end

  assign ram_en = ~stall & ~rst;
  assign ram_we = (is_store & ram_en) ? byte_en : 4'b0000;

  data_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_data_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (alu_res[AW+1:2]),
    .wdata (store_word),
    .rdata (ram_rdata)
  );

  always_comb begin
    control_next = control;
    if (is_misaligned) control_next.reg_write = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_alu_res_reg <= '0;
      wb_control_reg <= '0;
      misaligned_reg <= 1'b0;
      load_valid_reg <= 1'b0;
      lane_reg       <= 2'b00;
      funct3_reg     <= 3'b000;
    end else if (!stall) begin
      wb_alu_res_reg <= alu_res;
      wb_control_reg <= control_next;
      misaligned_reg <= is_misaligned;
      load_valid_reg <= is_load;
      lane_reg       <= alu_res[1:0];
      funct3_reg     <= control.mem_funct3;
    end
  end

  // Extraction runs on the RAM output using the lane/size captured with the
  // address; everything here holds under stall because its inputs do.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;

  assign byte_sel = ram_rdata[{lane_reg, 3'b000} +: 8];
  assign half_sel = ram_rdata[{lane_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_value = '0;
    if (load_valid_reg) begin
      case (funct3_reg)
        MEM_B:   load_value = {{24{byte_sel[7]}}, byte_sel};
        MEM_BU:  load_value = {24'd0, byte_sel};
        MEM_H:   load_value = {{16{half_sel[15]}}, half_sel};
        MEM_HU:  load_value = {16'd0, half_sel};
        MEM_W:   load_value = ram_rdata;
        default: load_value = '0;
      endcase
    end
  end

  assign wb_alu_res  = wb_alu_res_reg;
  assign wb_mem_data = load_value;
  assign wb_control  = wb_control_reg;
  assign misaligned  = misaligned_reg;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage. A byte-addressed reference memory
// predicts every output cycle; the driver queues predictions and a monitor
// compares them against the DUT shortly after each rising edge.
import common_pkg::*;

module tb_memory_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_res;
  logic [31:0] mem_data;
  control_t    control;
  logic        stall;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_data;
  control_t    wb_control;
  logic        misaligned;

  memory_stage dut (
    .clk         (clk),
    .rst         (rst),
    .alu_res     (alu_res),
    .mem_data    (mem_data),
    .control     (control),
    .stall       (stall),
    .wb_alu_res  (wb_alu_res),
    .wb_mem_data (wb_mem_data),
    .wb_control  (wb_control),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    control_t    ctl;
    logic        mis;
    string       tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       last_exp;
  logic [7:0] ref_bytes [4096];  // default DEPTH_WORDS=1024 -> 4 KiB, aliased
  int         checks;
  int         failures;

  function automatic control_t mk_ctl(input logic rw, input logic mr, input logic mw,
                                      input logic [2:0] f3, input logic [4:0] rd);
    control_t c;
    c.reg_write  = rw;
    c.mem_read   = mr;
    c.mem_write  = mw;
    c.mem_funct3 = f3;
    c.rd         = rd;
    return c;
  endfunction

  task automatic chk(input string name, input string tag,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s [%s] actual=%08h required=%08h", name, tag, act, req);
    end
  endtask

  // Reference model: issue one cycle of inputs and queue the predicted outputs.
  task automatic step(input logic r, input logic s, input logic [31:0] a,
                      input logic [31:0] d, input control_t c, input string tag);
    exp_t e;
    int   size;
    int   base;
    logic [31:0] v;
    @(negedge clk);
    rst = r; stall = s; alu_res = a; mem_data = d; control = c;
    e.tag = tag;
    if (r) begin
      e.alu = '0; e.data = '0; e.ctl = '0; e.mis = 1'b0;
    end else if (s) begin
      e = last_exp;
      e.tag = tag;
    end else begin
      case (c.mem_funct3)
        3'd0, 3'd4: size = 1;
        3'd1, 3'd5: size = 2;
        3'd2:       size = 4;
        default:    size = 0;
      endcase
      e.alu  = a;
      e.ctl  = c;
      e.mis  = (c.mem_read || c.mem_write) && (size == 0 || (a % size) != 0);
      e.data = '0;
      if (e.mis) e.ctl.reg_write = 1'b0;
      base = int'(a % 4096);
      if (c.mem_write && !e.mis) begin
        for (int i = 0; i < size; i++) ref_bytes[base + i] = 8'(d >> (8 * i));
      end else if (c.mem_read && !e.mis) begin
        v = '0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if (c.mem_funct3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (c.mem_funct3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        e.data = v;
      end
    end
    last_exp = e;
    exp_q.push_back(e);
  endtask

  // Monitor: each edge latches the oldest queued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("txn %s alu=%08h data=%08h ctl=%03h mis=%0d",
                 e.tag, wb_alu_res, wb_mem_data, wb_control, misaligned);
        chk("wb_alu_res",  e.tag, wb_alu_res, e.alu);
        chk("wb_mem_data", e.tag, wb_mem_data, e.data);
        chk("wb_control",  e.tag, 32'(wb_control), 32'(e.ctl));
        chk("misaligned",  e.tag, 32'(misaligned), 32'(e.mis));
      end
    end
  end

  localparam logic [2:0] LD_CODES [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  localparam logic [2:0] ST_CODES [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

  initial begin
    control_t nop;
    logic [31:0] a;
    logic [2:0]  f3;
    int          pick;
    checks = 0; failures = 0;
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h00;
    nop = mk_ctl(1'b0, 1'b0, 1'b0, 3'd0, 5'd0);
    last_exp = '{alu: '0, data: '0, ctl: '0, mis: 1'b0, tag: "init"};
    rst = 1'b1; stall = 1'b0; alu_res = '0; mem_data = '0; control = nop;

    step(1'b1, 1'b0, 32'h0, 32'h0, nop, "reset0");
    step(1'b1, 1'b0, 32'h0, 32'h0, nop, "reset1");

    // Clear the region used below so the RAM matches the model.
    for (int w = 0; w < 64; w++)
      step(1'b0, 1'b0, 32'(w * 4), 32'h0, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "clear");

    step(1'b0, 1'b0, 32'h10, 32'hDEADBEEF, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_10");
    step(1'b0, 1'b0, 32'h10, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd3), "lw_10");

    step(1'b0, 1'b0, 32'h10, 32'h0, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw0_10");
    step(1'b0, 1'b0, 32'h13, 32'h80, mk_ctl(1'b0, 1'b0, 1'b1, MEM_B, 5'd0), "sb_13");
    step(1'b0, 1'b0, 32'h13, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_B, 5'd4), "lb_13");
    step(1'b0, 1'b0, 32'h13, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_BU, 5'd5), "lbu_13");
    step(1'b0, 1'b0, 32'h10, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd6), "lw_10b");

    step(1'b0, 1'b0, 32'h22, 32'h8001, mk_ctl(1'b0, 1'b0, 1'b1, MEM_H, 5'd0), "sh_22");
    step(1'b0, 1'b0, 32'h22, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_H, 5'd7), "lh_22");
    step(1'b0, 1'b0, 32'h22, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_HU, 5'd8), "lhu_22");
    step(1'b0, 1'b0, 32'h20, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd9), "lw_20");

    step(1'b0, 1'b0, 32'h11, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd10), "lw_11_mis");
    step(1'b0, 1'b0, 32'h12, 32'hFFFFFFFF, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_12_mis");
    step(1'b0, 1'b0, 32'h10, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd11), "lw_10c");

    step(1'b0, 1'b0, 32'h20, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd12), "lw_pre_stall");
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_40_stall");
    step(1'b0, 1'b0, 32'h40, 32'hCAFEF00D, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_40_go");
    step(1'b0, 1'b0, 32'h40, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd13), "lw_40");

    step(1'b0, 1'b0, 32'h30, 32'h12345678, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_30");
    step(1'b1, 1'b0, 32'h30, 32'hAAAAAAAA, mk_ctl(1'b0, 1'b0, 1'b1, MEM_W, 5'd0), "sw_30_rst");
    step(1'b0, 1'b0, 32'h30, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd14), "lw_30");
    step(1'b1, 1'b1, 32'h30, 32'h0, nop, "rst_over_stall");

    step(1'b0, 1'b0, 32'h34, 32'h55667788, mk_ctl(1'b0, 1'b1, 1'b1, MEM_W, 5'd0), "rw_34");
    step(1'b0, 1'b0, 32'h34, 32'h0, mk_ctl(1'b1, 1'b1, 1'b0, MEM_W, 5'd15), "lw_34");
    step(1'b0, 1'b0, 32'h1234_5678, 32'h0, mk_ctl(1'b1, 1'b0, 1'b0, 3'd7, 5'd16), "alu_pass");

    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 99));
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      if (pick < 25) begin
        step(1'b0, ($urandom_range(0, 9) == 0), $urandom, $urandom,
             mk_ctl(1'($urandom), 1'b0, 1'b0, 3'($urandom), 5'($urandom)), "rnd_alu");
      end else if (pick < 60) begin
        f3 = ST_CODES[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) != 0) a[1:0] = (f3 == 3'd2) ? 2'b00 : {a[1], 1'b0};
        step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), a, $urandom,
             mk_ctl(1'b0, 1'($urandom_range(0, 7) == 0), 1'b1, f3, 5'($urandom)), "rnd_st");
      end else begin
        f3 = LD_CODES[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) != 0) a[1:0] = (f3 == 3'd2) ? 2'b00 : {a[1], 1'b0};
        step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), a, 32'h0,
             mk_ctl(1'($urandom), 1'b1, 1'b0, f3, 5'($urandom)), "rnd_ld");
      end
    end

    step(1'b0, 1'b0, 32'h0, 32'h0, nop, "drain");
    repeat (3) @(negedge clk);
    chk("queue_drained", "end", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
